// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and state encoding for the CPU/DMA memory bus arbiter.
// Holds the BURST_MAX/CPU_GAP defaults and the counter width.
package mem_bus_arbiter_pkg;

  localparam int unsigned BurstMaxDefault = 4;
  localparam int unsigned CpuGapDefault   = 2;
  localparam int unsigned CntWidth        = 4;
  localparam int unsigned BusWidth        = 16;

  typedef enum logic [1:0] {
    StCpuOwn  = 2'd0,
    StHandoff = 2'd1,
    StDmaOwn  = 2'd2,
    StReturn  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_counter.sv
// Small saturating counter with load, increment and decrement.
// Load has priority over increment, which has priority over decrement.
module arb_counter
  import mem_bus_arbiter_pkg::*;
(
  input  logic                MCLK,
  input  logic                reset,
  input  logic                load_i,
  input  logic [CntWidth-1:0] load_val_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] count_o
);

  localparam logic [CntWidth-1:0] CntMax = '1;

  logic [CntWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the memory bus between the CPU and a DMA engine with bounded bursts,
// a guaranteed CPU gap between grants and idle handoff/return cycles.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned BURST_MAX = BurstMaxDefault,
  parameter int unsigned CPU_GAP   = CpuGapDefault
) (
  input  logic                MCLK,
  input  logic                reset,
  input  logic [BusWidth-1:0] cpuMAB,
  input  logic [BusWidth-1:0] cpuMDBout,
  input  logic                cpuMW,
  input  logic                cpuBW,
  input  logic                urgent,
  input  logic                dmaReq,
  input  logic [BusWidth-1:0] dmaMAB,
  input  logic [BusWidth-1:0] dmaMDBout,
  input  logic                dmaMW,
  input  logic                dmaBW,
  output logic [BusWidth-1:0] MAB,
  output logic [BusWidth-1:0] MDBout,
  output logic                MW,
  output logic                BW,
  output logic                cpuHold,
  output logic                dmaGnt,
  output logic                dmaAck
);

  localparam logic [CntWidth-1:0] BurstLast = CntWidth'(BURST_MAX - 1);
  localparam logic [CntWidth-1:0] GapInit   = CntWidth'(CPU_GAP);

  arb_state_e state_q, state_d;
  logic       hold_q, hold_d;
  logic       gnt_q, gnt_d;

  logic                burst_load, burst_inc;
  logic                gap_load, gap_dec;
  logic [CntWidth-1:0] burst_cnt, gap_cnt;
  logic                gap_ready;
  logic                dma_ack;

  arb_counter u_burst_cnt (
    .MCLK       (MCLK),
    .reset      (reset),
    .load_i     (burst_load),
    .load_val_i ('0),
    .inc_i      (burst_inc),
    .dec_i      (1'b0),
    .count_o    (burst_cnt)
  );

  arb_counter u_gap_cnt (
    .MCLK       (MCLK),
    .reset      (reset),
    .load_i     (gap_load),
    .load_val_i (GapInit),
    .inc_i      (1'b0),
    .dec_i      (gap_dec),
    .count_o    (gap_cnt)
  );

  // The gap is judged on the post-decrement value so CPU_GAP=N yields exactly
  // N CPU-owned cycles between RETURN and the next HANDOFF (minimum one).
  assign gap_ready = (gap_cnt <= 4'd1);

  always_comb begin
    state_d    = state_q;
    burst_load = 1'b0;
    burst_inc  = 1'b0;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    dma_ack    = 1'b0;
    if (reset) begin
      state_d = StCpuOwn;
    end else begin
      unique case (state_q)
        StCpuOwn: begin
          gap_dec = 1'b1;
          if (dmaReq && !urgent && gap_ready) begin
            state_d    = StHandoff;
            burst_load = 1'b1;
          end
        end
        StHandoff: state_d = StDmaOwn;
        StDmaOwn: begin
          dma_ack   = dmaReq;
          burst_inc = dmaReq;
          if (!dmaReq || urgent || (burst_cnt == BurstLast)) begin
            state_d = StReturn;
          end
        end
        StReturn: begin
          state_d  = StCpuOwn;
          gap_load = 1'b1;
        end
        default: state_d = StCpuOwn;
      endcase
    end
    hold_d = (state_d != StCpuOwn);
    gnt_d  = (state_d == StDmaOwn);
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q <= StCpuOwn;
      hold_q  <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  // Reset forces the CPU path so the reset-vector fetch is never blocked.
  always_comb begin
    MAB    = '0;
    MDBout = '0;
    MW     = 1'b0;
    BW     = 1'b0;
    if (reset || (state_q == StCpuOwn)) begin
      MAB    = cpuMAB;
      MDBout = cpuMDBout;
      MW     = cpuMW;
      BW     = cpuBW;
    end else if ((state_q == StDmaOwn) && dmaReq) begin
      MAB    = dmaMAB;
      MDBout = dmaMDBout;
      MW     = dmaMW;
      BW     = dmaBW;
    end
  end

  assign cpuHold = hold_q;
  assign dmaGnt  = gnt_q;
  assign dmaAck  = dma_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus hand-written
// sequences for the CPU-write handoff and reset-mid-burst corners.
module tb_mem_bus_arbiter;

  localparam logic [15:0] CpuA = 16'h0100;
  localparam logic [15:0] CpuD = 16'hC0DE;
  localparam logic [15:0] DmaA = 16'h0200;
  localparam logic [15:0] DmaD = 16'hDA7A;

  localparam logic [1:0] SrcCpu  = 2'd0;
  localparam logic [1:0] SrcDma  = 2'd1;
  localparam logic [1:0] SrcIdle = 2'd2;

  logic        MCLK = 1'b0;
  logic        reset;
  logic [15:0] cpuMAB, cpuMDBout, dmaMAB, dmaMDBout;
  logic        cpuMW, cpuBW, urgent, dmaReq, dmaMW, dmaBW;
  logic [15:0] MAB, MDBout;
  logic        MW, BW, cpuHold, dmaGnt, dmaAck;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       rst;
    logic       dreq;
    logic       urg;
    logic       cmw;
    logic       dmw;
    logic [1:0] src;
    logic       hold;
    logic       gnt;
    logic       ack;
  } vec_t;

  vec_t vecs[$];

  mem_bus_arbiter #(
    .BURST_MAX (4),
    .CPU_GAP   (2)
  ) dut (
    .MCLK      (MCLK),
    .reset     (reset),
    .cpuMAB    (cpuMAB),
    .cpuMDBout (cpuMDBout),
    .cpuMW     (cpuMW),
    .cpuBW     (cpuBW),
    .urgent    (urgent),
    .dmaReq    (dmaReq),
    .dmaMAB    (dmaMAB),
    .dmaMDBout (dmaMDBout),
    .dmaMW     (dmaMW),
    .dmaBW     (dmaBW),
    .MAB       (MAB),
    .MDBout    (MDBout),
    .MW        (MW),
    .BW        (BW),
    .cpuHold   (cpuHold),
    .dmaGnt    (dmaGnt),
    .dmaAck    (dmaAck)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic dreq, input logic urg, input logic cmw,
                     input logic dmw, input logic [1:0] src, input logic hold,
                     input logic gnt, input logic ack);
    vec_t v;
    v.rst = rst; v.dreq = dreq; v.urg = urg; v.cmw = cmw; v.dmw = dmw;
    v.src = src; v.hold = hold; v.gnt = gnt; v.ack = ack;
    vecs.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge MCLK);
    #1;
  endtask

  initial begin
    logic [63:0] exp;
    logic [31:0] bus;
    logic        emw, ebw;

    reset = 1'b1; urgent = 1'b0; dmaReq = 1'b0;
    cpuMAB = CpuA; cpuMDBout = CpuD; cpuMW = 1'b0; cpuBW = 1'b1;
    dmaMAB = DmaA; dmaMDBout = DmaD; dmaMW = 1'b0; dmaBW = 1'b1;
    next_cycle();
    next_cycle();

    //   rst dreq urg cmw dmw src      hold gnt ack
    add(1, 1, 0, 0, 0, SrcCpu,  0, 0, 0);  // held in reset, bus follows CPU
    add(0, 1, 0, 1, 0, SrcCpu,  0, 0, 0);  // grant decided, CPU write still visible
    add(0, 1, 0, 1, 1, SrcIdle, 1, 0, 0);  // HANDOFF
    add(0, 1, 0, 0, 1, SrcDma,  1, 1, 1);
    add(0, 1, 0, 0, 0, SrcDma,  1, 1, 1);
    add(0, 1, 0, 0, 1, SrcDma,  1, 1, 1);
    add(0, 1, 0, 0, 0, SrcDma,  1, 1, 1);  // 4th transfer ends burst
    add(0, 1, 0, 1, 1, SrcIdle, 1, 0, 0);  // RETURN
    add(0, 1, 0, 0, 0, SrcCpu,  0, 0, 0);  // gap cycle 1
    add(0, 1, 0, 0, 0, SrcCpu,  0, 0, 0);  // gap cycle 2
    add(0, 1, 0, 1, 1, SrcIdle, 1, 0, 0);  // HANDOFF
    add(0, 1, 0, 0, 0, SrcDma,  1, 1, 1);
    add(0, 1, 1, 0, 0, SrcDma,  1, 1, 1);  // urgent: this transfer completes
    add(0, 1, 1, 1, 1, SrcIdle, 1, 0, 0);  // RETURN
    add(0, 1, 1, 0, 0, SrcCpu,  0, 0, 0);
    add(0, 1, 1, 0, 0, SrcCpu,  0, 0, 0);
    add(0, 1, 1, 0, 0, SrcCpu,  0, 0, 0);  // gap expired but urgent blocks
    add(0, 1, 0, 0, 0, SrcCpu,  0, 0, 0);
    add(0, 0, 0, 1, 1, SrcIdle, 1, 0, 0);  // HANDOFF, dmaReq dropped
    add(0, 0, 0, 1, 1, SrcIdle, 1, 1, 0);  // idle DMA_OWN cycle
    add(0, 0, 0, 1, 1, SrcIdle, 1, 0, 0);  // RETURN
    add(0, 0, 0, 0, 0, SrcCpu,  0, 0, 0);
    add(0, 0, 0, 0, 0, SrcCpu,  0, 0, 0);
    add(0, 1, 0, 0, 0, SrcCpu,  0, 0, 0);
    add(0, 1, 0, 0, 0, SrcIdle, 1, 0, 0);  // HANDOFF
    add(0, 1, 0, 0, 1, SrcDma,  1, 1, 1);  // single DMA write to 0200
    add(0, 0, 0, 0, 1, SrcIdle, 1, 1, 0);
    add(0, 0, 0, 0, 0, SrcIdle, 1, 0, 0);  // RETURN
    add(0, 0, 0, 0, 0, SrcCpu,  0, 0, 0);
    add(0, 0, 0, 0, 0, SrcCpu,  0, 0, 0);
    add(0, 0, 0, 0, 0, SrcCpu,  0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; dmaReq = vecs[i].dreq; urgent = vecs[i].urg;
      cpuMW = vecs[i].cmw; dmaMW = vecs[i].dmw;
      cpuMAB = CpuA; cpuMDBout = CpuD;
      case (vecs[i].src)
        SrcCpu:  begin bus = {CpuA, CpuD}; emw = vecs[i].cmw; ebw = 1'b1; end
        SrcDma:  begin bus = {DmaA, DmaD}; emw = vecs[i].dmw; ebw = 1'b1; end
        default: begin bus = '0;           emw = 1'b0;        ebw = 1'b0; end
      endcase
      exp = {27'd0, vecs[i].hold, vecs[i].gnt, vecs[i].ack, emw, ebw, bus};
      @(negedge MCLK);
      check($sformatf("vec%0d", i), {27'd0, cpuHold, dmaGnt, dmaAck, MW, BW, MAB, MDBout}, exp);
      next_cycle();
    end

    // CPU write coincides with a DMA request: write lands, then HANDOFF.
    cpuMAB = 16'h0300; cpuMDBout = 16'h1234; cpuMW = 1'b1; dmaReq = 1'b1; dmaMW = 1'b0;
    @(negedge MCLK);
    check("cpu_write", {29'd0, cpuHold, dmaGnt, MW, MAB, MDBout}, {29'd0, 3'b001, 16'h0300, 16'h1234});
    next_cycle();
    @(negedge MCLK);
    check("handoff_idle", {29'd0, cpuHold, dmaGnt, MW, MAB, MDBout}, {29'd0, 3'b100, 32'd0});
    next_cycle();
    cpuMW = 1'b0;
    @(negedge MCLK);
    check("dma1", {29'd0, cpuHold, dmaGnt, dmaAck, MAB, MDBout}, {29'd0, 3'b111, DmaA, DmaD});
    next_cycle();
    @(negedge MCLK);
    check("dma2", {29'd0, cpuHold, dmaGnt, dmaAck, MAB, MDBout}, {29'd0, 3'b111, DmaA, DmaD});
    next_cycle();

    // Reset on the 3rd DMA cycle: no ack, bus goes straight back to the CPU.
    reset = 1'b1;
    @(negedge MCLK);
    check("reset_dma3", {47'd0, dmaAck, MAB}, {47'd0, 1'b0, 16'h0300});
    next_cycle();
    reset = 1'b0; cpuMAB = 16'h0400;
    @(negedge MCLK);
    check("after_reset", {45'd0, cpuHold, dmaGnt, dmaAck, MAB}, {45'd0, 3'b000, 16'h0400});
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
